bcd_to_bin: RTL and testbench

//   Sequential BCD-to-binary converter: sign + 3 BCD digits -> signed 8-bit two's complement.

---
 rtl/bcd_to_bin.sv | 151 +++++++++++++++
 tb/tb_bcd_to_bin.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential sign + 3-digit BCD to signed 8-bit binary converter.
// Uses reverse double-dabble: each SHIFT cycle shifts {bcd_sr, mag_sr} right by
// one, then subtracts 3 from every BCD digit that is >= 8.
// Optional feature macro: BCD_SATURATE_EN. When it is defined, out-of-range
// results clamp to +127 / -128. When it is undefined, they give 0. Both builds
// set error=1 for out-of-range values.
//
// Handshake: start is sampled only in IDLE or DONE. The sampling edge latches
// the operands. data_ready=1 (DONE state) marks binary/error as valid, and
// they hold until the next accepted start. start during SHIFT is ignored.
module bcd_to_bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sign,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [7:0] binary,
  output logic       busy,
  output logic       data_ready,
  output logic       error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic        sign_r;
  logic [11:0] bcd_sr;
  logic [9:0]  mag_sr;
  logic [3:0]  count;
  logic [7:0]  binary_r;
  logic        error_r;

  logic        digit_bad;
  logic [21:0] shifted;
  logic [11:0] bcd_adj;
  logic [9:0]  mag_next;
  logic [7:0]  res_bin;
  logic        res_err;

  // Reverse double-dabble correction for a single BCD digit.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  // Detect any non-decimal digit on the live inputs at the start edge.
  always_comb begin
    digit_bad = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
  end

  // Shift, then correct each digit of the shifted BCD register.
  always_comb begin
    shifted  = {bcd_sr, mag_sr} >> 1;
    mag_next = shifted[9:0];
    bcd_adj  = {dabble_adj(shifted[21:18]),
                dabble_adj(shifted[17:14]),
                dabble_adj(shifted[13:10])};
  end

  // Range check and sign application on the final magnitude.
  always_comb begin
    res_bin = 8'd0;
    res_err = 1'b0;
    if (!sign_r) begin
      if (mag_next <= 10'd127) begin
        res_bin = mag_next[7:0];
      end else begin
        res_err = 1'b1;
`ifdef BCD_SATURATE_EN
        res_bin = 8'h7F;
`else
        res_bin = 8'h00;
`endif
      end
    end else begin
      if (mag_next <= 10'd128) begin
        // 128 maps to 8'h80, and -0 maps to 0.
        res_bin = 8'd0 - mag_next[7:0];
      end else begin
        res_err = 1'b1;
`ifdef BCD_SATURATE_EN
        res_bin = 8'h80;
`else
        res_bin = 8'h00;
`endif
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sign_r   <= 1'b0;
      bcd_sr   <= 12'd0;
      mag_sr   <= 10'd0;
      count    <= 4'd0;
      binary_r <= 8'd0;
      error_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sign_r <= sign;
            bcd_sr <= {hundreds, tens, ones};
            mag_sr <= 10'd0;
            count  <= 4'd10;
            if (digit_bad) begin
              state    <= DONE;
              binary_r <= 8'd0;
              error_r  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_adj;
          mag_sr <= mag_next;
          count  <= count - 4'd1;
          if (count == 4'd1) begin
            state    <= DONE;
            binary_r <= res_bin;
            error_r  <= res_err;
          end
        end
        default: begin
          state    <= IDLE;
          sign_r   <= 1'b0;
          bcd_sr   <= 12'd0;
          mag_sr   <= 10'd0;
          count    <= 4'd0;
          binary_r <= 8'd0;
          error_r  <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy       = (state == SHIFT);
    data_ready = (state == DONE);
    binary     = binary_r;
    error      = error_r;
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed bench for bcd_to_bin.
module tb_bcd_to_bin;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sign;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] binary;
  logic       busy;
  logic       data_ready;
  logic       error;

  int checks_run;
  int errors_seen;

  bcd_to_bin dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sign       (sign),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .binary     (binary),
    .busy       (busy),
    .data_ready (data_ready),
    .error      (error)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_run++;
    if (obs !== exp) begin
      errors_seen++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed value plus range handling for either build.
  task automatic ref_model(input bit s, input int mag, output logic [7:0] b, output logic e);
    int v;
    v = s ? -mag : mag;
    if (v >= -128 && v <= 127) begin
      b = 8'(v);
      e = 1'b0;
    end else begin
      e = 1'b1;
`ifdef BCD_SATURATE_EN
      b = s ? 8'h80 : 8'h7F;
`else
      b = 8'h00;
`endif
    end
  endtask

  // Issue one request and return its result. Lat counts the edges from
  // the start edge until data_ready is seen.
  task automatic convert(input bit s, input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o, output int lat);
    @(negedge clk);
    sign = s; hundreds = h; tens = t; ones = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!data_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input bit s, input logic [3:0] h,
                           input logic [3:0] t, input logic [3:0] o,
                           input logic [7:0] exp_b, input logic exp_e, input int exp_lat);
    int lat;
    convert(s, h, t, o, lat);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_bin"}, binary, exp_b);
    check_val({tag, "_err"}, error, exp_e);
  endtask

  initial begin
    int lat;
    int cur;
    int nxt;
    int m;
    logic [7:0] eb;
    logic       ee;

    checks_run  = 0;
    errors_seen = 0;
    rst = 1'b0; start = 1'b0; sign = 1'b0;
    hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
    repeat (3) @(negedge clk);
    check_val("rst_bin", binary, 8'd0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_rdy", data_ready, 1'b0);
    check_val("rst_err", error, 1'b0);
    rst = 1'b1;

    // Produce a nonzero result, then abort a conversion with reset.
    run_check("pre", 1'b0, 4'd0, 4'd9, 4'd9, 8'd99, 1'b0, 11);
    @(negedge clk);
    sign = 1'b0; hundreds = 4'd0; tens = 4'd5; ones = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("shift_busy", busy, 1'b1);
    check_val("shift_rdy", data_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_bin", binary, 8'd0);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_rdy", data_ready, 1'b0);
    check_val("abort_err", error, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check_val("abort_no_rdy", data_ready, 1'b0);

    // Boundary values.
    run_check("p127", 1'b0, 4'd1, 4'd2, 4'd7, 8'd127, 1'b0, 11);
    run_check("n128", 1'b1, 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 11);
    run_check("neg0", 1'b1, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 11);
    run_check("n1",   1'b1, 4'd0, 4'd0, 4'd1, 8'hFF, 1'b0, 11);
    run_check("p0",   1'b0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 11);
    run_check("p85",  1'b0, 4'd0, 4'd8, 4'd5, 8'h55, 1'b0, 11);
`ifdef BCD_SATURATE_EN
    run_check("p128", 1'b0, 4'd1, 4'd2, 4'd8, 8'h7F, 1'b1, 11);
    run_check("n999", 1'b1, 4'd9, 4'd9, 4'd9, 8'h80, 1'b1, 11);
    run_check("n129", 1'b1, 4'd1, 4'd2, 4'd9, 8'h80, 1'b1, 11);
`else
    run_check("p128", 1'b0, 4'd1, 4'd2, 4'd8, 8'h00, 1'b1, 11);
    run_check("n999", 1'b1, 4'd9, 4'd9, 4'd9, 8'h00, 1'b1, 11);
    run_check("n129", 1'b1, 4'd1, 4'd2, 4'd9, 8'h00, 1'b1, 11);
`endif
    // Invalid digits: immediate result, including when issued from DONE.
    run_check("bad_a", 1'b0, 4'd0, 4'hA, 4'd3, 8'h00, 1'b1, 1);
    run_check("bad_f", 1'b1, 4'hF, 4'd0, 4'd0, 8'h00, 1'b1, 1);
    run_check("bad_o", 1'b0, 4'd1, 4'd0, 4'hC, 8'h00, 1'b1, 1);

    // Start pulses and input changes during SHIFT must be ignored.
    @(negedge clk);
    sign = 1'b0; hundreds = 4'd0; tens = 4'd4; ones = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sign = 1'b1; hundreds = 4'd9; tens = 4'hB; ones = 4'd1; start = 1'b1;
    @(negedge clk);
    check_val("ign_busy", busy, 1'b1);
    start = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd7;
    lat = 3;
    while (!data_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("ign_lat", lat, 11);
    check_val("ign_bin", binary, 8'd42);
    check_val("ign_err", error, 1'b0);

    // Back-to-back sweep of -128..127 with start held high.
    cur = -128;
    m = 128;
    @(negedge clk);
    sign = 1'b1; hundreds = 4'(m / 100); tens = 4'((m / 10) % 10); ones = 4'(m % 10);
    start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!data_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("sweep_first_lat", lat, 11);
    while (cur <= 127) begin
      m = (cur < 0) ? -cur : cur;
      ref_model(cur < 0, m, eb, ee);
      check_val("sweep_bin", binary, eb);
      check_val("sweep_err", error, ee);
      nxt = cur + 1;
      if (nxt > 127) break;
      m = (nxt < 0) ? -nxt : nxt;
      sign = (nxt < 0); hundreds = 4'(m / 100); tens = 4'((m / 10) % 10); ones = 4'(m % 10);
      @(negedge clk);
      lat = 1;
      while (!data_ready && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check_val("sweep_lat", lat, 11);
      cur = nxt;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks_run, errors_seen);
    $finish;
  end

endmodule
